serial_alu_ctrl: RTL and testbench

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_pkg.sv | 25 ++
 rtl/serial_alu_ctrl_alu_1_bit.sv | 32 +++
 rtl/serial_alu_ctrl.sv | 112 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode helpers for the
// bit-serial ALU controller.
package serial_alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic op_valid(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_NOR);
    endfunction

    // Only ADD and SUB report carry and overflow.
    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_alu_1_bit.sv
// One-bit ALU slice: optional inversion of each input, then AND, OR or
// full-adder sum. The ALUop bits map directly onto ainvert/binvert/operation.
module ALU_1_bit (
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       ainvert,
    input  logic       binvert,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);

    logic a_sel;
    logic b_sel;
    logic sum;

    assign a_sel     = a ^ ainvert;
    assign b_sel     = b ^ binvert;
    assign sum       = a_sel ^ b_sel ^ carry_in;
    assign carry_out = (a_sel & b_sel) | (a_sel & carry_in) | (b_sel & carry_in);

    always_comb begin
        unique case (operation)
            2'b00:   result = a_sel & b_sel;
            2'b01:   result = a_sel | b_sel;
            2'b10:   result = sum;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: sequences a single 1-bit ALU over WIDTH cycles,
// LSB first, and reports result plus carry/overflow/zero/op_err flags.
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             op_err
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             alu_result;
    logic             alu_carry;
    logic [WIDTH-1:0] result_next;
    logic             last_bit;

    ALU_1_bit u_alu (
        .a         (a_q[idx]),
        .b         (b_q[idx]),
        .carry_in  (carry_q),
        .ainvert   (op_q[3]),
        .binvert   (op_q[2]),
        .operation (op_q[1:0]),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    // NOTE: every signal assigned in always_comb gets a full default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        result_next      = result;
        result_next[idx] = alu_result;
    end

    assign last_bit = (idx == IDX_LAST);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // NOTE: all state, including the operand copies, is cleared by the async
    // reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= op;
                        idx       <= '0;
                        carry_q   <= (op == OP_SUB);
                        result    <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        // An invalid op finishes immediately with a zero result.
                        zero      <= !op_valid(op);
                        op_err    <= !op_valid(op);
                        state     <= op_valid(op) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    result  <= result_next;
                    carry_q <= alu_carry;
                    idx     <= idx + 1'b1;
                    if (last_bit) begin
                        carry_out <= op_is_arith(op_q) & alu_carry;
                        overflow  <= op_is_arith(op_q) & (carry_q ^ alu_carry);
                        zero      <= (result_next == '0);
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl at WIDTH=8.
module tb_serial_alu_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       op_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .op_err    (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency counts negedges after the accepting edge; -1 means timeout.
    task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int busy_cycles, output bit overlap);
        lat = -1;
        busy_cycles = 0;
        overlap = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, result, carry_out, overflow, zero, op_err} !== 13'd0)
            $display("FAIL reset_outputs got=%h want=0",
                     {busy, done, result, carry_out, overflow, zero, op_err});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_and();
        int lat, bc; bit ov;
        run_op(4'b0000, 8'hA5, 8'h0F, lat, bc, ov);
        total_cnt++;
        if (lat !== 9) $display("FAIL and_latency got=%0d want=9", lat); else pass_cnt++;
        total_cnt++;
        if (bc !== 8) $display("FAIL and_busy_cycles got=%0d want=8", bc); else pass_cnt++;
        total_cnt++;
        if (ov !== 1'b0) $display("FAIL and_busy_done_overlap got=%b want=0", ov); else pass_cnt++;
        total_cnt++;
        if ({result, carry_out, overflow, zero, op_err} !== {8'h05, 4'b0000})
            $display("FAIL and_result got=%h c=%b v=%b z=%b e=%b want=05 0 0 0 0",
                     result, carry_out, overflow, zero, op_err);
        else pass_cnt++;
        // Held after done, in IDLE.
        @(negedge clk);
        total_cnt++;
        if ({done, busy, result} !== {2'b00, 8'h05})
            $display("FAIL and_hold got=%b%b %h want=00 05", done, busy, result);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int lat, bc; bit ov;
        run_op(4'b0010, 8'hFF, 8'h01, lat, bc, ov);
        total_cnt++;
        if (lat !== 9 || {result, carry_out, overflow, zero} !== {8'h00, 3'b101})
            $display("FAIL add_ff_01 got=lat%0d %h c=%b v=%b z=%b want=lat9 00 1 0 1",
                     lat, result, carry_out, overflow, zero);
        else pass_cnt++;
        run_op(4'b0010, 8'h7F, 8'h01, lat, bc, ov);
        total_cnt++;
        if ({result, carry_out, overflow, zero} !== {8'h80, 3'b010})
            $display("FAIL add_7f_01 got=%h c=%b v=%b z=%b want=80 0 1 0",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
    endtask

    task automatic test_sub_nor();
        int lat, bc; bit ov;
        run_op(4'b0110, 8'h05, 8'h07, lat, bc, ov);
        total_cnt++;
        if ({result, carry_out, overflow, zero} !== {8'hFE, 3'b000})
            $display("FAIL sub_05_07 got=%h c=%b v=%b z=%b want=fe 0 0 0",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
        run_op(4'b0110, 8'h80, 8'h01, lat, bc, ov);
        total_cnt++;
        if ({result, carry_out, overflow} !== {8'h7F, 2'b11})
            $display("FAIL sub_80_01 got=%h c=%b v=%b want=7f 1 1",
                     result, carry_out, overflow);
        else pass_cnt++;
        run_op(4'b1100, 8'h00, 8'h00, lat, bc, ov);
        total_cnt++;
        if ({result, carry_out, overflow, zero} !== {8'hFF, 3'b000})
            $display("FAIL nor_00_00 got=%h c=%b v=%b z=%b want=ff 0 0 0",
                     result, carry_out, overflow, zero);
        else pass_cnt++;
        run_op(4'b0001, 8'h30, 8'h0C, lat, bc, ov);
        total_cnt++;
        if ({result, carry_out} !== {8'h3C, 1'b0})
            $display("FAIL or_30_0c got=%h c=%b want=3c 0", result, carry_out);
        else pass_cnt++;
    endtask

    task automatic test_invalid();
        int lat, bc; bit ov;
        run_op(4'b0101, 8'h12, 8'h34, lat, bc, ov);
        total_cnt++;
        if (lat !== 1 || bc !== 0)
            $display("FAIL invalid_timing got=lat%0d busy%0d want=lat1 busy0", lat, bc);
        else pass_cnt++;
        total_cnt++;
        if ({result, carry_out, overflow, zero, op_err} !== {8'h00, 4'b0011})
            $display("FAIL invalid_flags got=%h c=%b v=%b z=%b e=%b want=00 0 0 1 1",
                     result, carry_out, overflow, zero, op_err);
        else pass_cnt++;
        // A following valid op clears op_err.
        run_op(4'b0000, 8'hFF, 8'h00, lat, bc, ov);
        total_cnt++;
        if ({result, zero, op_err} !== {8'h00, 2'b10})
            $display("FAIL invalid_then_and got=%h z=%b e=%b want=00 1 0", result, zero, op_err);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        @(negedge clk);
        start = 1'b1; op = 4'b0001; a = 8'h30; b = 8'h0C;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                start = 1'b1; op = 4'b0010; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        total_cnt++;
        if (lat !== 9 || result !== 8'h3C)
            $display("FAIL ignored_start got=lat%0d %h want=lat9 3c", lat, result);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL start_not_queued got=busy%b done%b want=00", busy, done);
        else pass_cnt++;
        begin
            int l2, bc; bit ov;
            run_op(4'b0110, 8'h10, 8'h01, l2, bc, ov);
            total_cnt++;
            if (l2 !== 9 || result !== 8'h0F)
                $display("FAIL next_start_accepted got=lat%0d %h want=lat9 0f", l2, result);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        int lat, bc; bit ov;
        @(negedge clk);
        start = 1'b1; op = 4'b0010; a = 8'h55; b = 8'h22;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, result, carry_out, overflow, zero, op_err} !== 13'd0)
            $display("FAIL abort_immediate got=%h want=0",
                     {busy, done, result, carry_out, overflow, zero, op_err});
        else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%b want=0", saw_done);
        else pass_cnt++;
        run_op(4'b0010, 8'h03, 8'h04, lat, bc, ov);
        total_cnt++;
        if (lat !== 9 || {result, carry_out, overflow, zero} !== {8'h07, 3'b000})
            $display("FAIL after_reset_add got=lat%0d %h c=%b v=%b z=%b want=lat9 07 0 0 0",
                     lat, result, carry_out, overflow, zero);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_and();
        test_add();
        test_sub_nor();
        test_invalid();
        test_start_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
